des_round_sequencer: RTL and testbench
======================================

DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 32: max cycles to wait for stage_status after a stage_set pulse.
REQ-002 Parameter NUM_ROUNDS, default 16: Feistel rounds per block.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  upstream block valid.
REQ-006 in_ready  output  1  sequencer accepts a block.
REQ-007 in_block  input  [0:63]  plaintext/ciphertext block, bit 0 = MSB.
REQ-008 in_decrypt  input  1  1 = decrypt (reverse subkey order), sampled with in_block.
REQ-009 out_valid  output  1  result block valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_block  output  [0:63]  result block.
REQ-012 stage_set  output  1  one-cycle start pulse to the selected datapath stage.
REQ-013 stage_sel  output  2  0 = initial permutation, 1 = round, 2 = inverse initial permutation.
REQ-014 stage_data  output  [0:63]  operand to the selected stage (work register).
REQ-015 stage_status  input  1  stage finished; stage_result valid this cycle.
REQ-016 stage_result  input  [0:63]  stage output.
REQ-017 round_idx  output  4  current round 0..15.
REQ-018 subkey_idx  output  4  round_idx for encrypt, 15-round_idx for decrypt.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 err  output  1  one-cycle pulse on stage timeout.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE: in_ready=1; on in_valid&&in_ready capture in_block into work register, in_decrypt into mode reg, stage_sel=0, round_idx=0, go ISSUE.
REQ-023 ISSUE: stage_set=1 for exactly one cycle, stage_data=work register; go WAIT, clear timeout counter.
REQ-024 WAIT: stage_status in the ISSUE cycle SHALL be ignored; on stage_status=1 capture stage_result into work register and advance.
REQ-025 Advance: IP -> round 0; round k<15 -> round k+1; round 15 -> FP; FP -> DONE; else -> ISSUE.
REQ-026 stage_sel, round_idx, subkey_idx SHALL remain stable from ISSUE through the WAIT cycle in which stage_status is accepted.
REQ-027 DONE: out_valid=1, out_block=work register, held stable until out_ready=1; the handshake cycle returns to IDLE.
REQ-028 in_ready SHALL be 0 in ISSUE, WAIT, DONE; no new block accepted until return to IDLE (no overlap).
REQ-029 Latency with stage_status in first WAIT cycle: accept at cycle 0, out_valid at cycle 37 (18 stages x 2 cycles + 1).
REQ-030 Timeout: counter increments each WAIT cycle; reaching TIMEOUT without stage_status -> err=1 one cycle, block dropped, go IDLE.
REQ-031 stage_status in the same cycle the counter hits TIMEOUT SHALL count as success (status wins).
REQ-032 stage_status outside WAIT SHALL be ignored.
REQ-033 Sequencer does not perform the final L/R swap; the datapath owns it.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE, in_ready=1 in the following cycle, out_valid=0, stage_set=0, err=0, busy=0, stage_sel=0, round_idx=0, subkey_idx=0, work register and out_block=0.
REQ-035 Reset mid-block SHALL abandon the block with no out_valid and no err.

Structure
REQ-036 Package des_seq_pkg SHALL hold the state enum, stage_sel codes (SEL_IP, SEL_ROUND, SEL_FP), NUM_ROUNDS default and TIMEOUT default.
REQ-037 Timeout counter SHALL be the sub-module des_stage_timer (clear, enable, expired).

Verification
REQ-038 Encrypt, in_block=64'h6332af83b4aeb468, stage model status 1 cycle after set -> 18 stage_set pulses, sel sequence 0,1x16,2, subkey_idx 0..15, out_valid at cycle 37.
REQ-039 Decrypt same block -> subkey_idx 15 down to 0; out_block equals value from the stage model chain.
REQ-040 Stage model withholds status on round 5 for 32 cycles -> err pulse once, busy falls, no out_valid, in_ready=1 next cycle.
REQ-041 out_ready held 0 for 10 cycles in DONE -> out_valid and out_block stable; in_valid asserted meanwhile not accepted.
REQ-042 rst_n=0 during round 8 -> next cycle all outputs at reset values; following block completes normally.
REQ-043 Status pulse while in ISSUE and in IDLE -> ignored; sequence and result unchanged.

Source files
------------

// File: rtl/des_seq_pkg.sv
// Shared types and defaults for the DES round sequencer: FSM states,
// datapath stage select codes and the subkey ordering helper.
package des_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic [1:0] SEL_IP    = 2'd0;
    localparam logic [1:0] SEL_ROUND = 2'd1;
    localparam logic [1:0] SEL_FP    = 2'd2;

    localparam int DEF_NUM_ROUNDS = 16;
    localparam int DEF_TIMEOUT    = 32;

    // Decryption walks the key schedule backwards.
    function automatic logic [3:0] subkey_of(input logic [3:0] round,
                                             input logic       decrypt,
                                             input int         num_rounds);
        return decrypt ? (4'(num_rounds - 1) - round) : round;
    endfunction

endpackage

// File: rtl/des_round_sequencer_if.sv
// Block handshake plus datapath-stage control bundle for the DES sequencer.
// master = sequencer side, slave = upstream/downstream/datapath side.
interface des_round_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [0:63] in_block;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_block;
    logic        stage_set;
    logic [1:0]  stage_sel;
    logic [0:63] stage_data;
    logic        stage_status;
    logic [0:63] stage_result;
    logic [3:0]  round_idx;
    logic [3:0]  subkey_idx;
    logic        busy;
    logic        err;

    modport master (
        input  in_valid, in_block, in_decrypt, out_ready, stage_status, stage_result,
        output in_ready, out_valid, out_block, stage_set, stage_sel, stage_data,
               round_idx, subkey_idx, busy, err
    );

    modport slave (
        output in_valid, in_block, in_decrypt, out_ready, stage_status, stage_result,
        input  in_ready, out_valid, out_block, stage_set, stage_sel, stage_data,
               round_idx, subkey_idx, busy, err
    );

endinterface

// File: rtl/des_stage_timer.sv
// Counts cycles spent waiting on a datapath stage; expired is asserted during
// the TIMEOUT-th enabled cycle after a clear.
module des_stage_timer
    import des_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/des_round_sequencer.sv
// Sequences one DES block through IP, NUM_ROUNDS Feistel rounds and FP on an
// external datapath, one stage at a time, with a per-stage timeout.
module des_round_sequencer
    import des_seq_pkg::*;
#(
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS
) (
    input logic                  clk,
    input logic                  rst_n,
    des_round_sequencer_if.master bus
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic [0:63] r_work;
    logic        r_decrypt;
    logic [1:0]  r_sel;
    logic [3:0]  r_round;

    logic w_accept;
    logic w_status_ok;
    logic w_expired;
    logic w_timeout;
    logic w_last_round;
    logic w_timer_clr;
    logic w_timer_en;

    assign w_accept     = (r_state == ST_IDLE) && bus.in_valid;
    assign w_status_ok  = (r_state == ST_WAIT) && bus.stage_status;
    // A status arriving on the expiry cycle still counts as success.
    assign w_timeout    = w_expired && !bus.stage_status;
    assign w_last_round = (r_round == 4'(NUM_ROUNDS - 1));
    assign w_timer_clr  = (r_state == ST_ISSUE);
    assign w_timer_en   = (r_state == ST_WAIT);

    des_stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_timer_clr),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.stage_set = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.stage_set = 1'b1;
                w_state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.stage_status) begin
                    w_state_nxt = (r_sel == SEL_FP) ? ST_DONE : ST_ISSUE;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stage select and round only move on the edge that accepts a status,
    // so they are stable across the whole ISSUE/WAIT pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work    <= '0;
            r_decrypt <= 1'b0;
            r_sel     <= SEL_IP;
            r_round   <= '0;
        end else if (w_accept) begin
            r_work    <= bus.in_block;
            r_decrypt <= bus.in_decrypt;
            r_sel     <= SEL_IP;
            r_round   <= '0;
        end else if (w_status_ok) begin
            r_work <= bus.stage_result;
            case (r_sel)
                SEL_IP: begin
                    r_sel   <= SEL_ROUND;
                    r_round <= '0;
                end
                SEL_ROUND: begin
                    if (w_last_round) r_sel <= SEL_FP;
                    else              r_round <= r_round + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.stage_data = r_work;
    assign bus.out_block  = r_work;
    assign bus.stage_sel  = r_sel;
    assign bus.round_idx  = r_round;
    assign bus.subkey_idx = subkey_of(r_round, r_decrypt, NUM_ROUNDS);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.err        = w_timeout && rst_n;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer with a behavioural datapath-stage
// responder; the same per-stage transform is chained in software as the reference result.
module tb_des_round_sequencer;
    import des_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_round_sequencer_if bus();

    des_round_sequencer #(.TIMEOUT(32), .NUM_ROUNDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder state and observation records
    logic        model_status = 1'b0;
    logic        inj_idle = 1'b0;
    logic        inj_issue = 1'b0;
    int          hold_round = -1;
    int          hold_dly = 0;
    int          pend = 0;
    logic [63:0] pend_res = '0;
    int          n_set = 0;
    logic [1:0]  rec_sel [0:255];
    logic [3:0]  rec_sub [0:255];
    int          rec_cyc [0:255];
    int          err_cnt = 0;
    int          err_cyc = 0;
    int          ov_cnt = 0;

    assign bus.stage_status = model_status | inj_idle;

    function automatic logic [63:0] model(input logic [1:0] sel, input logic [3:0] sk,
                                          input logic [63:0] d);
        case (sel)
            2'd0:    return d ^ 64'h0123_4567_89ab_cdef;
            2'd1:    return {d[59:0], d[63:60]} ^ {60'b0, sk};
            default: return ~d;
        endcase
    endfunction

    function automatic logic [63:0] chain(input logic [63:0] blk, input logic dec);
        logic [63:0] x;
        x = model(2'd0, 4'd0, blk);
        for (int r = 0; r < 16; r++) x = model(2'd1, dec ? 4'(15 - r) : 4'(r), x);
        return model(2'd2, 4'd0, x);
    endfunction

    always begin
        @(posedge clk); #1;
        model_status     = 1'b0;
        bus.stage_result = 64'hdead_beef_dead_beef;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                model_status     = 1'b1;
                bus.stage_result = pend_res;
            end
        end
        if (bus.stage_set) begin
            rec_sel[n_set] = bus.stage_sel;
            rec_sub[n_set] = bus.subkey_idx;
            rec_cyc[n_set] = cyc;
            n_set++;
            pend_res = model(bus.stage_sel, bus.subkey_idx, bus.stage_data);
            if (bus.stage_sel == SEL_ROUND && int'(bus.round_idx) == hold_round) pend = hold_dly;
            else pend = 1;
            if (inj_issue) model_status = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (bus.out_valid) ov_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    int c0 = 0;

    task automatic start_block(input logic [63:0] blk, input logic dec, input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_block   = blk;
        bus.in_decrypt = dec;
        bus.in_valid   = 1'b1;
        c0 = cyc;
        step();
        bus.in_valid = 1'b0;
        bus.in_block = '0;
    endtask

    task automatic wait_out(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.out_valid) begin
                lat = cyc - c0;
                break;
            end
            step();
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_in_ready"},   64'(bus.in_ready),   64'd1);
        chk({p, "_out_valid"},  64'(bus.out_valid),  64'd0);
        chk({p, "_stage_set"},  64'(bus.stage_set),  64'd0);
        chk({p, "_err"},        64'(bus.err),        64'd0);
        chk({p, "_busy"},       64'(bus.busy),       64'd0);
        chk({p, "_stage_sel"},  64'(bus.stage_sel),  64'd0);
        chk({p, "_round_idx"},  64'(bus.round_idx),  64'd0);
        chk({p, "_subkey_idx"}, 64'(bus.subkey_idx), 64'd0);
        chk({p, "_out_block"},  64'(bus.out_block),  64'd0);
        chk({p, "_stage_data"}, 64'(bus.stage_data), 64'd0);
    endtask

    task automatic chk_order(input int base, input logic dec, input string p);
        for (int i = 0; i < 18; i++) begin
            chk({p, "_sel"}, 64'(rec_sel[base + i]), (i == 0) ? 64'd0 : (i == 17) ? 64'd2 : 64'd1);
            if (i >= 1 && i <= 16)
                chk({p, "_subkey"}, 64'(rec_sub[base + i]), dec ? 64'(16 - i) : 64'(i - 1));
        end
    endtask

    localparam logic [63:0] BLK_A = 64'h6332_af83_b4ae_b468;
    localparam logic [63:0] BLK_B = 64'h0123_4567_89ab_cdef;
    localparam logic [63:0] BLK_C = 64'hfedc_ba98_7654_3210;

    int          base;
    int          lat;
    int          e0;
    int          o0;
    logic        ok;
    logic [63:0] held;

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_block   = '0;
        bus.in_decrypt = 1'b0;
        bus.out_ready  = 1'b0;

        // Reset state
        rst_n = 1'b0;
        step(); step(); step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        // Encrypt: 18 stages, IP / 16 rounds / FP, subkeys ascending, latency 37
        base = n_set;
        start_block(BLK_A, 1'b0, "enc");
        wait_out(100, lat);
        chk("enc_latency", 64'(lat), 64'd37);
        chk("enc_nset", 64'(n_set - base), 64'd18);
        chk_order(base, 1'b0, "enc");
        chk("enc_out_block", 64'(bus.out_block), chain(BLK_A, 1'b0));
        handshake();
        chk("enc_idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("enc_idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Decrypt the same block: subkeys descending
        base = n_set;
        start_block(BLK_A, 1'b1, "dec");
        wait_out(100, lat);
        chk("dec_latency", 64'(lat), 64'd37);
        chk_order(base, 1'b1, "dec");
        chk("dec_out_block", 64'(bus.out_block), chain(BLK_A, 1'b1));
        handshake();

        // Round 5 never answers: one err pulse 32 cycles after its stage_set
        hold_round = 5; hold_dly = 0;
        base = n_set; e0 = err_cnt; o0 = ov_cnt;
        start_block(BLK_B, 1'b0, "tmo");
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            step();
        end
        chk("tmo_busy", 64'(bus.busy), 64'd0);
        chk("tmo_in_ready", 64'(bus.in_ready), 64'd1);
        chk("tmo_nset", 64'(n_set - base), 64'd7);
        chk("tmo_err_cnt", 64'(err_cnt - e0), 64'd1);
        chk("tmo_err_delay", 64'(err_cyc - rec_cyc[base + 6]), 64'd32);
        step(); step();
        chk("tmo_no_out_valid", 64'(ov_cnt - o0), 64'd0);
        chk("tmo_err_single", 64'(err_cnt - e0), 64'd1);

        // Status on the 32nd wait cycle wins over the timeout
        hold_dly = 32;
        e0 = err_cnt;
        start_block(BLK_B, 1'b0, "edge");
        wait_out(200, lat);
        chk("edge_latency", 64'(lat), 64'd68);
        chk("edge_no_err", 64'(err_cnt - e0), 64'd0);
        chk("edge_out_block", 64'(bus.out_block), chain(BLK_B, 1'b0));
        handshake();
        hold_round = -1; hold_dly = 0;

        // Back-pressure: output held 10 cycles while a new block is offered
        start_block(BLK_B, 1'b1, "bp");
        wait_out(100, lat);
        held = bus.out_block;
        chk("bp_out_block", held, chain(BLK_B, 1'b1));
        base = n_set;
        bus.in_valid = 1'b1;
        bus.in_block = BLK_C;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bus.out_valid || bus.out_block !== held || bus.in_ready) ok = 1'b0;
        end
        chk("bp_stable", 64'(ok), 64'd1);
        bus.in_valid = 1'b0;
        handshake();
        step();
        chk("bp_not_accepted", 64'(n_set - base), 64'd0);
        chk("bp_busy", 64'(bus.busy), 64'd0);

        // Reset during round 8 abandons the block silently
        start_block(BLK_C, 1'b1, "mid");
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.stage_sel == SEL_ROUND && bus.round_idx == 4'd8) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("mid_reached_round8", 64'(ok), 64'd1);
        e0 = err_cnt; o0 = ov_cnt;
        rst_n = 1'b0;
        step();
        chk_reset("mid");
        rst_n = 1'b1;
        step(); step(); step();
        chk("mid_no_err", 64'(err_cnt - e0), 64'd0);
        chk("mid_no_out_valid", 64'(ov_cnt - o0), 64'd0);
        start_block(BLK_C, 1'b0, "post");
        wait_out(100, lat);
        chk("post_latency", 64'(lat), 64'd37);
        chk("post_out_block", 64'(bus.out_block), chain(BLK_C, 1'b0));
        handshake();

        // Stray status in IDLE and during ISSUE is ignored
        inj_idle = 1'b1;
        step(); step();
        inj_idle = 1'b0;
        chk("stray_idle_busy", 64'(bus.busy), 64'd0);
        inj_issue = 1'b1;
        base = n_set;
        start_block(BLK_C, 1'b1, "stray");
        wait_out(100, lat);
        inj_issue = 1'b0;
        chk("stray_latency", 64'(lat), 64'd37);
        chk("stray_nset", 64'(n_set - base), 64'd18);
        chk("stray_out_block", 64'(bus.out_block), chain(BLK_C, 1'b1));
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
